condlogic_banked: RTL and testbench

//   Parametrised conditional-execution unit for the multicycle ARM core.
//   - Sits between the main decoder/FSM and the datapath.
//   - Gates RegWrite, MemWrite and PCWrite on the instruction condition field.
//   - Holds NCTX banked NZCV flag sets, for mode/context switching.
//   - Updates flags through a deferred write pipeline of depth WB_DELAY.
//   - Supports a one-cycle bank-to-bank flag copy (save/restore of status).

---
 rtl/condlogic_banked.sv | 124 ++++++++++++
 tb/tb_condlogic_banked.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/condlogic_banked.sv
// Conditional-execution unit: ARM condition check, write gating, banked NZCV
// flag sets with a deferred flag-write pipeline and a one-cycle bank copy.
module condlogic_banked #(
   parameter int unsigned  NCTX     = 2,
   parameter int unsigned  WB_DELAY = 1,
   parameter bit           GATE_CUR = 1'b1,
   localparam int unsigned CW       = (NCTX > 1) ? $clog2(NCTX) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [3:0]    Cond,
   input  logic [3:0]    ALUFlags,
   input  logic [1:0]    FlagW,
   input  logic          PCS,
   input  logic          NextPC,
   input  logic          RegW,
   input  logic          MemW,
   input  logic [CW-1:0] CtxSel,
   input  logic          CtxCopy,
   input  logic [CW-1:0] CopySrc,
   input  logic [CW-1:0] CopyDst,
   output logic          CondEx,
   output logic [3:0]    Flags,
   output logic          FlagPend,
   output logic          PCWrite,
   output logic          RegWrite,
   output logic          MemWrite
);

   typedef struct packed {
      logic [1:0]    fw;
      logic [CW-1:0] ctx;
   } stage_t;

   logic [3:0] bank     [NCTX];
   logic [3:0] bank_nxt [NCTX];
   stage_t     pipe     [WB_DELAY];

   logic       ctx_ok;
   logic [3:0] cur;
   logic       n, z, c, v;
   logic       cond_pass;
   stage_t     exit_s;
   logic [1:0] wr_en;
   logic       wr_ok;
   logic       copy_ok;

   // Active bank read; out-of-range selector reads as all-zero flags
   assign ctx_ok       = 32'(CtxSel) < NCTX;
   assign cur          = ctx_ok ? bank[CtxSel] : 4'b0000;
   assign {n, z, c, v} = cur;
   assign Flags        = cur;

   always_comb begin
      cond_pass = 1'b0;
      case (Cond)
         4'b0000: cond_pass = z;
         4'b0001: cond_pass = ~z;
         4'b0010: cond_pass = c;
         4'b0011: cond_pass = ~c;
         4'b0100: cond_pass = n;
         4'b0101: cond_pass = ~n;
         4'b0110: cond_pass = v;
         4'b0111: cond_pass = ~v;
         4'b1000: cond_pass = c & ~z;
         4'b1001: cond_pass = ~c | z;
         4'b1010: cond_pass = ~(n ^ v);
         4'b1011: cond_pass = n ^ v;
         4'b1100: cond_pass = ~z & ~(n ^ v);
         4'b1101: cond_pass = z | (n ^ v);
         4'b1110: cond_pass = 1'b1;
         4'b1111: cond_pass = 1'b0;
      endcase
   end

   assign CondEx   = ctx_ok & cond_pass;
   assign PCWrite  = (PCS & CondEx) | NextPC;
   assign RegWrite = RegW & CondEx;
   assign MemWrite = MemW & CondEx;

   // Deferred flag-write pipe; entries keep their captured bank index
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int s = 0; s < int'(WB_DELAY); s++) pipe[s] <= '0;
      end else begin
         pipe[0] <= {FlagW & {2{CondEx}}, CtxSel};
         for (int s = 1; s < int'(WB_DELAY); s++) pipe[s] <= pipe[s-1];
      end
   end

   assign exit_s  = pipe[WB_DELAY-1];
   assign wr_en   = exit_s.fw & (GATE_CUR ? FlagW : 2'b11);
   assign wr_ok   = 32'(exit_s.ctx) < NCTX;
   assign copy_ok = CtxCopy && (32'(CopySrc) < NCTX) && (32'(CopyDst) < NCTX)
                    && (CopySrc != CopyDst);

   // Copy lands first, then the pipe write overrides the fields it enables
   always_comb begin
      for (int unsigned i = 0; i < NCTX; i++) begin
         bank_nxt[i] = bank[i];
         if (copy_ok && (32'(CopyDst) == i)) bank_nxt[i] = bank[CopySrc];
         if (wr_ok && (32'(exit_s.ctx) == i)) begin
            if (wr_en[1]) bank_nxt[i][3:2] = ALUFlags[3:2];
            if (wr_en[0]) bank_nxt[i][1:0] = ALUFlags[1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < NCTX; i++) bank[i] <= 4'b0000;
      end else begin
         for (int unsigned i = 0; i < NCTX; i++) bank[i] <= bank_nxt[i];
      end
   end

   always_comb begin
      FlagPend = 1'b0;
      for (int s = 0; s < int'(WB_DELAY); s++) begin
         if ((pipe[s].fw != 2'b00) && (pipe[s].ctx == CtxSel)) FlagPend = 1'b1;
      end
   end

endmodule

// File: tb/tb_condlogic_banked.sv
// Bench for condlogic_banked: two configurations share one stimulus stream and
// are compared every cycle against a due-time based flag model.
module tb_condlogic_banked;

   localparam int unsigned NC_A = 4;
   localparam int unsigned WB_A = 2;
   localparam bit          GT_A = 1'b1;
   localparam int unsigned NC_B = 3;
   localparam int unsigned WB_B = 1;
   localparam bit          GT_B = 1'b0;
   localparam int unsigned CW   = 2;

   localparam logic [3:0] AL = 4'b1110;
   localparam logic [3:0] NV = 4'b1111;
   localparam logic [3:0] EQ = 4'b0000;

   logic          clk = 1'b0;
   logic          reset;
   logic [3:0]    Cond, ALUFlags;
   logic [1:0]    FlagW;
   logic          PCS, NextPC, RegW, MemW, CtxCopy;
   logic [CW-1:0] CtxSel, CopySrc, CopyDst;

   logic       a_condex, a_pend, a_pcw, a_rw, a_mw;
   logic [3:0] a_flags;
   logic       b_condex, b_pend, b_pcw, b_rw, b_mw;
   logic [3:0] b_flags;

   always #5 clk = ~clk;

   condlogic_banked #(.NCTX(NC_A), .WB_DELAY(WB_A), .GATE_CUR(GT_A)) u_a (
      .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
      .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .CtxSel(CtxSel),
      .CtxCopy(CtxCopy), .CopySrc(CopySrc), .CopyDst(CopyDst),
      .CondEx(a_condex), .Flags(a_flags), .FlagPend(a_pend),
      .PCWrite(a_pcw), .RegWrite(a_rw), .MemWrite(a_mw));

   condlogic_banked #(.NCTX(NC_B), .WB_DELAY(WB_B), .GATE_CUR(GT_B)) u_b (
      .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
      .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .CtxSel(CtxSel),
      .CtxCopy(CtxCopy), .CopySrc(CopySrc), .CopyDst(CopyDst),
      .CondEx(b_condex), .Flags(b_flags), .FlagPend(b_pend),
      .PCWrite(b_pcw), .RegWrite(b_rw), .MemWrite(b_mw));

   int          checks   = 0;
   int          failures = 0;
   int unsigned cyc      = 0;

   // Model: bank contents plus pending writes keyed by the cycle they land in
   logic [3:0]  mbank [2][4];
   logic [1:0]  pfw   [2][8];
   int unsigned pctx  [2][8];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int unsigned nc(input int d);
      return (d == 0) ? NC_A : NC_B;
   endfunction

   function automatic int unsigned wb(input int d);
      return (d == 0) ? WB_A : WB_B;
   endfunction

   function automatic bit gt(input int d);
      return (d == 0) ? GT_A : GT_B;
   endfunction

   // ARM conditions: odd codes are the complement of the preceding even code
   function automatic logic passes(input logic [3:0] cc, input logic [3:0] f);
      logic fn, fz, fc, fv, base;
      {fn, fz, fc, fv} = f;
      case (cc[3:1])
         3'd0:    base = fz;
         3'd1:    base = fc;
         3'd2:    base = fn;
         3'd3:    base = fv;
         3'd4:    base = fc & ~fz;
         3'd5:    base = (fn == fv);
         3'd6:    base = ~fz & (fn == fv);
         default: base = 1'b1;
      endcase
      return cc[0] ? ~base : base;
   endfunction

   function automatic logic [3:0] mflags(input int d);
      return (32'(CtxSel) < nc(d)) ? mbank[d][CtxSel] : 4'b0000;
   endfunction

   function automatic logic mcondex(input int d);
      return (32'(CtxSel) < nc(d)) && passes(Cond, mflags(d));
   endfunction

   function automatic logic mpend(input int d);
      for (int s = 0; s < 8; s++)
         if ((pfw[d][s] != 2'b00) && (pctx[d][s] == 32'(CtxSel))) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [8:0] obs(input int d);
      if (d == 0) return {a_condex, a_flags, a_pend, a_pcw, a_rw, a_mw};
      return {b_condex, b_flags, b_pend, b_pcw, b_rw, b_mw};
   endfunction

   task automatic sample();
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         logic [8:0] o;
         logic       cx;
         string      nm;
         o  = obs(d);
         cx = mcondex(d);
         nm = (d == 0) ? "A" : "B";
         chk($sformatf("%s.CondEx", nm),   32'(o[8]),   32'(cx));
         chk($sformatf("%s.Flags", nm),    32'(o[7:4]), 32'(mflags(d)));
         chk($sformatf("%s.FlagPend", nm), 32'(o[3]),   32'(mpend(d)));
         chk($sformatf("%s.PCWrite", nm),  32'(o[2]),   32'((PCS & cx) | NextPC));
         chk($sformatf("%s.RegWrite", nm), 32'(o[1]),   32'(RegW & cx));
         chk($sformatf("%s.MemWrite", nm), 32'(o[0]),   32'(MemW & cx));
      end
   endtask

   task automatic advance();
      for (int d = 0; d < 2; d++) begin
         logic [3:0]  nb [4];
         logic [1:0]  en, fw;
         int unsigned s, k;
         if (reset) begin
            for (int i = 0; i < 4; i++) mbank[d][i] = 4'b0000;
            for (int i = 0; i < 8; i++) pfw[d][i] = 2'b00;
         end else begin
            for (int i = 0; i < 4; i++) nb[i] = mbank[d][i];
            if (CtxCopy && (32'(CopySrc) < nc(d)) && (32'(CopyDst) < nc(d)) && (CopySrc != CopyDst))
               nb[CopyDst] = mbank[d][CopySrc];
            s  = cyc % 8;
            en = pfw[d][s] & (gt(d) ? FlagW : 2'b11);
            k  = pctx[d][s];
            if (k < nc(d)) begin
               if (en[1]) nb[k][3:2] = ALUFlags[3:2];
               if (en[0]) nb[k][1:0] = ALUFlags[1:0];
            end
            pfw[d][s] = 2'b00;
            fw = FlagW & {2{mcondex(d)}};
            if (fw != 2'b00) begin
               pfw[d][(cyc + wb(d)) % 8]  = fw;
               pctx[d][(cyc + wb(d)) % 8] = 32'(CtxSel);
            end
            for (int i = 0; i < 4; i++) mbank[d][i] = nb[i];
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic cycle();
      sample();
      advance();
   endtask

   task automatic drive(input logic rst, input logic [3:0] cc, input logic [1:0] fw,
                        input logic [3:0] alu, input logic [CW-1:0] ctx);
      reset = rst; Cond = cc; FlagW = fw; ALUFlags = alu; CtxSel = ctx;
      PCS = 1'b0; NextPC = 1'b0; RegW = 1'b0; MemW = 1'b0;
      CtxCopy = 1'b0; CopySrc = '0; CopyDst = '0;
   endtask

   task automatic idle(input int n);
      drive(1'b0, AL, 2'b00, 4'b0000, 2'd0);
      repeat (n) cycle();
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 4; i++) mbank[d][i] = 4'b0000;
         for (int i = 0; i < 8; i++) begin pfw[d][i] = 2'b00; pctx[d][i] = 0; end
      end

      drive(1'b1, AL, 2'b00, 4'b0000, 2'd0);
      advance();
      cycle();

      // EQ fails on cleared flags, passes once Z has been written
      drive(1'b0, EQ, 2'b00, 4'b0000, 2'd0); RegW = 1'b1;
      sample();
      chk("t1.A.Flags_rst", 32'(a_flags), 32'h0);
      chk("t1.A.FlagPend_rst", 32'(a_pend), 32'h0);
      chk("t1.A.CondEx", 32'(a_condex), 32'h0);
      chk("t1.A.RegWrite", 32'(a_rw), 32'h0);
      advance();
      repeat (3) begin drive(1'b0, AL, 2'b11, 4'b0100, 2'd0); cycle(); end
      drive(1'b0, EQ, 2'b00, 4'b0000, 2'd0); RegW = 1'b1;
      sample();
      chk("t1.A.CondEx_z", 32'(a_condex), 32'h1);
      chk("t1.A.RegWrite_z", 32'(a_rw), 32'h1);
      advance();
      idle(3);

      // Two-cycle latency and FlagW gating in the write cycle
      drive(1'b0, AL, 2'b11, 4'b0000, 2'd0); cycle();
      drive(1'b0, AL, 2'b00, 4'b0000, 2'd0);
      sample(); chk("t2.A.FlagPend_t1", 32'(a_pend), 32'h1); advance();
      drive(1'b0, AL, 2'b11, 4'b1001, 2'd0);
      sample(); chk("t2.A.FlagPend_t2", 32'(a_pend), 32'h1); advance();
      drive(1'b0, AL, 2'b00, 4'b0000, 2'd0);
      sample(); chk("t2.A.Flags_t3", 32'(a_flags), 32'h9); advance();
      cycle();
      sample();
      chk("t3.A.Flags_gated", 32'(a_flags), 32'h9);
      chk("t3.A.FlagPend_idle", 32'(a_pend), 32'h0);
      advance();

      // CV-only write: ungated config updates CV, gated config keeps flags
      drive(1'b0, AL, 2'b01, 4'b0000, 2'd0); cycle();
      drive(1'b0, NV, 2'b00, 4'b0011, 2'd0); cycle();
      sample(); chk("t3.B.CV", 32'(b_flags[1:0]), 32'h3); advance();
      sample(); chk("t3.A.Flags_keep", 32'(a_flags), 32'h9); advance();

      // Bank copy 1 -> 3 (out of range for the 3-bank config)
      repeat (3) begin drive(1'b0, AL, 2'b11, 4'b0100, 2'd1); cycle(); end
      idle(3);
      drive(1'b0, AL, 2'b00, 4'b0000, 2'd1);
      CtxCopy = 1'b1; CopySrc = 2'd1; CopyDst = 2'd3;
      cycle();
      drive(1'b0, EQ, 2'b00, 4'b0000, 2'd3);
      sample();
      chk("t4.A.Flags_dst", 32'(a_flags), 32'h4);
      chk("t4.A.CondEx_dst", 32'(a_condex), 32'h1);
      chk("t4.B.Flags_oob", 32'(b_flags), 32'h0);
      chk("t4.B.CondEx_oob", 32'(b_condex), 32'h0);
      advance();
      drive(1'b0, EQ, 2'b00, 4'b0000, 2'd1);
      sample(); chk("t4.A.Flags_src", 32'(a_flags), 32'h4); advance();

      // Context switch while a write to bank 0 is in flight
      drive(1'b0, AL, 2'b11, 4'b0000, 2'd0); cycle();
      drive(1'b0, NV, 2'b00, 4'b0000, 2'd1); PCS = 1'b1;
      sample();
      chk("t5.A.FlagPend_sw", 32'(a_pend), 32'h0);
      chk("t6.A.PCWrite_nv", 32'(a_pcw), 32'h0);
      advance();
      drive(1'b0, NV, 2'b11, 4'b0010, 2'd1);
      sample(); chk("t5.A.FlagPend_sw2", 32'(a_pend), 32'h0); advance();
      drive(1'b0, AL, 2'b00, 4'b0000, 2'd1);
      sample(); chk("t5.A.Flags_bank1", 32'(a_flags), 32'h4); advance();
      drive(1'b0, AL, 2'b00, 4'b0000, 2'd0);
      sample(); chk("t5.A.Flags_bank0", 32'(a_flags), 32'h2); advance();

      // Reset in the middle of a pending write
      drive(1'b0, AL, 2'b11, 4'b1111, 2'd0); cycle();
      drive(1'b1, AL, 2'b11, 4'b1111, 2'd0); cycle();
      drive(1'b0, NV, 2'b11, 4'b1111, 2'd0); cycle();
      drive(1'b0, NV, 2'b00, 4'b0000, 2'd0);
      sample();
      chk("t6.A.Flags_rst", 32'(a_flags), 32'h0);
      chk("t6.B.Flags_rst", 32'(b_flags), 32'h0);
      advance();

      repeat (2000) begin
         reset    = ($urandom_range(0, 63) == 0);
         Cond     = ($urandom_range(0, 3) == 0) ? AL : 4'($urandom);
         FlagW    = 2'($urandom);
         ALUFlags = 4'($urandom);
         PCS      = 1'($urandom);
         NextPC   = 1'($urandom);
         RegW     = 1'($urandom);
         MemW     = 1'($urandom);
         CtxSel   = 2'($urandom);
         CtxCopy  = ($urandom_range(0, 7) == 0);
         CopySrc  = 2'($urandom);
         CopyDst  = 2'($urandom);
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
